chirp_seq_ctrl: RTL and testbench
=================================

// Module: chirp_seq_ctrl
// PURPOSE
//  Command parser and sequencer in front of the chirp generator. Consumes UART RX bytes (9600 bps link, 10 MHz clk),
//  decodes framed commands into SF/BW config registers and a symbol FIFO, then issues one start pulse per queued symbol,
//  waiting for the generator's active-low done between chirps. Sits between uart_rx and the chirp datapath.
// PARAMETERS
//  MAX_SF_WIDTH  8  width of spreading-factor register
//  BW_BITWIDTH   2  width of bandwidth-select register
//  ADDR_WIDTH    4  symbol FIFO address width; depth = 2**ADDR_WIDTH (16)
//  DATA_WIDTH    8  symbol / RX byte width
// PORTS
//  i_clk        in   1               system clock
//  i_rst_n      in   1               asynchronous active-low reset
//  i_rx_data    in   DATA_WIDTH      received UART byte
//  i_rx_valid   in   1               1-cycle strobe, i_rx_data valid
//  i_done_n     in   1               chirp generator done, active low
//  o_start      out  1               1-cycle pulse: generator latches o_symbol/o_sf/o_bw
//  o_symbol     out  DATA_WIDTH      symbol for current chirp
//  o_sf         out  MAX_SF_WIDTH    spreading factor config
//  o_bw         out  BW_BITWIDTH     bandwidth select config
//  o_busy       out  1               sequencer not idle
//  o_err        out  4               sticky flags {bad_cksum, fifo_ovf, busy_cfg, bad_cmd}
// BEHAVIOUR
//  Reset (async assert, sync release): o_start=0, o_symbol=0, o_sf=7, o_bw=0, o_busy=0, o_err=0, FIFO empty, FSMs idle.
//  Frame: 0xA5 hdr, OP, LEN, LEN payload bytes. Bytes only advance parser on i_rx_valid.
//  Parser FSM: P_HDR -(0xA5)-> P_OP -> P_LEN -> P_DATA (LEN bytes; skipped if LEN=0) -> P_EXEC (1 cycle) -> P_HDR.
//   Non-0xA5 byte in P_HDR discarded silently.
//  Opcodes (executed in P_EXEC, effects visible next cycle):
//   0x01 SET_SF  LEN=1: o_sf<=byte if 7..12 else bad_cmd, o_sf unchanged.
//   0x02 SET_BW  LEN=1: o_bw<=byte[BW_BITWIDTH-1:0].
//   0x03 LOAD    LEN=N: each payload byte pushed to FIFO as received; push when full -> byte dropped, fifo_ovf set.
//   0x04 START   LEN=0: sequencer S_IDLE->S_START; FIFO empty -> bad_cmd, no start.
//   0x05 ABORT   LEN=0: FIFO flushed, sequencer to S_IDLE same cycle; an in-flight chirp is not waited for.
//   Other OP, or LEN mismatch for 01/02/04/05 -> bad_cmd; payload still consumed, no effect.
//  SET_SF/SET_BW while o_busy=1 -> rejected, busy_cfg set (config stable across a burst). LOAD while busy is legal (append).
//  Sequencer FSM: S_IDLE -> S_START: pop FIFO, o_symbol<=head, o_start=1 one cycle -> S_WAIT.
//   S_WAIT ignores i_done_n in cycle immediately after o_start; first later cycle with i_done_n=0 ->
//   S_START if FIFO non-empty else S_IDLE. o_busy=1 in S_START/S_WAIT.
//   Min spacing between o_start pulses: 3 cycles.
//  FIFO push and pop in same cycle: both happen, count unchanged; pop from full frees slot for that push.
//  o_err bits sticky, cleared only by reset or opcode 0x06 CLR_ERR (LEN=0).
//  i_rx_valid every cycle permitted; no byte is lost by parser (FIFO overflow aside).
// CONFIGURATION
//  CHIRP_SEQ_CKSUM_EN defined: after payload, parser state P_CKSUM expects XOR of OP,LEN,payload;
//   mismatch -> bad_cksum set, frame discarded (LOAD bytes staged, committed to FIFO only on good checksum).
//  Not defined: no checksum byte; LOAD bytes pushed directly; bad_cksum bit tied 0.
// STRUCTURE
//  Package chirp_pkg: CMD_HDR=8'hA5, OP_* opcode localparams, SF_MIN=7/SF_MAX=12, ERR_* bit indices,
//   parser/sequencer state encodings.
//  Sub-module chirp_sym_fifo: sync FIFO (push/pop/flush, full/empty, count), reused elsewhere.
//  Parser, config regs and sequencer stay in this module.
// TESTING
//  Reset mid-burst: assert i_rst_n=0 during S_WAIT -> all outputs reset values immediately, FIFO empty.
//  A5 01 01 09 then A5 02 01 02 -> o_sf=9, o_bw=2, o_err=0; A5 01 01 0D -> o_sf stays 9, o_err=4'b0001.
//  A5 03 03 11 22 33, A5 04 00; i_done_n low 5 cycles after each start -> 3 o_start pulses, symbols 11,22,33, o_busy falls.
//  LOAD 17 bytes into empty FIFO -> 16 queued, fifo_ovf set; START with empty FIFO -> bad_cmd, no o_start.
//  SET_SF during burst -> busy_cfg set, o_sf unchanged; ABORT mid-burst -> o_busy=0 next cycle, no further o_start.
//  CHIRP_SEQ_CKSUM_EN: A5 03 01 44 46 -> 44 queued; A5 03 01 44 00 -> nothing queued, bad_cksum set.

Source files
------------

// File: rtl/chirp_pkg.sv
// Shared constants for the chirp command parser / sequencer: framing, opcodes,
// SF limits, error-flag bit positions and FSM state encodings.
package chirp_pkg;

    localparam logic [7:0] CMD_HDR    = 8'hA5;

    localparam logic [7:0] OP_SET_SF  = 8'h01;
    localparam logic [7:0] OP_SET_BW  = 8'h02;
    localparam logic [7:0] OP_LOAD    = 8'h03;
    localparam logic [7:0] OP_START   = 8'h04;
    localparam logic [7:0] OP_ABORT   = 8'h05;
    localparam logic [7:0] OP_CLR_ERR = 8'h06;

    localparam logic [7:0] SF_MIN = 8'd7;
    localparam logic [7:0] SF_MAX = 8'd12;

    localparam int unsigned ERR_W         = 4;
    localparam int unsigned ERR_BAD_CMD   = 0;
    localparam int unsigned ERR_BUSY_CFG  = 1;
    localparam int unsigned ERR_FIFO_OVF  = 2;
    localparam int unsigned ERR_BAD_CKSUM = 3;

    typedef enum logic [2:0] {
        P_HDR,
        P_OP,
        P_LEN,
        P_DATA,
        P_CKSUM,
        P_EXEC
    } parser_state_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } seq_state_e;

endpackage

// File: rtl/chirp_seq_ctrl_if.sv
// Byte-in / chirp-control bundle between uart_rx, the sequencer and the chirp datapath.
interface chirp_seq_ctrl_if #(
    parameter int unsigned MAX_SF_WIDTH = 8,
    parameter int unsigned BW_BITWIDTH  = 2,
    parameter int unsigned DATA_WIDTH   = 8
);
    logic [DATA_WIDTH-1:0]   i_rx_data;
    logic                    i_rx_valid;
    logic                    i_done_n;
    logic                    o_start;
    logic [DATA_WIDTH-1:0]   o_symbol;
    logic [MAX_SF_WIDTH-1:0] o_sf;
    logic [BW_BITWIDTH-1:0]  o_bw;
    logic                    o_busy;
    logic [3:0]              o_err;

    modport master (
        output i_rx_data, i_rx_valid, i_done_n,
        input  o_start, o_symbol, o_sf, o_bw, o_busy, o_err
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_done_n,
        output o_start, o_symbol, o_sf, o_bw, o_busy, o_err
    );
endinterface

// File: rtl/chirp_sym_fifo.sv
// Synchronous symbol FIFO with push/pop/flush. Pushes are staged until commit;
// discard rolls staged entries back (tie commit high for plain FIFO behaviour).
module chirp_sym_fifo #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  commit,
    input  logic                  discard,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] head_c,
    output logic                  full_c,
    output logic [ADDR_WIDTH:0]   count
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, stg_ptr, rd_ptr;
    logic [CW-1:0]         pend;
    logic                  do_pop_c, push_ok_c;
    logic [CW-1:0]         pend_nxt_c;
    logic [ADDR_WIDTH-1:0] stg_nxt_c;

    // Staged entries occupy slots; a same-cycle pop frees one for the push.
    assign full_c     = (count + pend) == CW'(DEPTH);
    assign do_pop_c   = pop && (count != '0);
    assign push_ok_c  = push && (!full_c || do_pop_c);
    assign pend_nxt_c = pend + CW'(push_ok_c);
    assign stg_nxt_c  = stg_ptr + ADDR_WIDTH'(push_ok_c);
    assign head_c     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok_c && !flush) begin
            mem[stg_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            stg_ptr <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pend    <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            stg_ptr <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pend    <= '0;
        end else begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(do_pop_c);
            if (commit) begin
                wr_ptr  <= stg_nxt_c;
                stg_ptr <= stg_nxt_c;
                count   <= count + pend_nxt_c - CW'(do_pop_c);
                pend    <= '0;
            end else if (discard) begin
                stg_ptr <= wr_ptr;
                count   <= count - CW'(do_pop_c);
                pend    <= '0;
            end else begin
                stg_ptr <= stg_nxt_c;
                count   <= count - CW'(do_pop_c);
                pend    <= pend_nxt_c;
            end
        end
    end
endmodule

// File: rtl/chirp_seq_ctrl.sv
// UART command parser, SF/BW config registers and chirp start sequencer.
// Optional CHIRP_SEQ_CKSUM_EN adds a trailing XOR checksum byte per frame.
module chirp_seq_ctrl
    import chirp_pkg::*;
#(
    parameter int unsigned MAX_SF_WIDTH = 8,
    parameter int unsigned BW_BITWIDTH  = 2,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    chirp_seq_ctrl_if.slave  bus
);
    logic                    rst_meta_n, rst_sync_n;
    parser_state_e           p_state;
    seq_state_e              seq_state, seq_next;
    logic [DATA_WIDTH-1:0]   op, len, cnt, data0;
    logic [MAX_SF_WIDTH-1:0] sf_q;
    logic [BW_BITWIDTH-1:0]  bw_q;
    logic [ERR_W-1:0]        err_q;
    logic [DATA_WIDTH-1:0]   symbol_q;
    logic                    start_q, busy_q;

    logic set_sf_c, set_bw_c, start_c, abort_c, clr_c, bad_cmd_c, busy_cfg_c, ovf_c, bad_cksum_c;
    logic fifo_push_c, fifo_pop_c, fifo_commit_c, fifo_discard_c, fifo_full_c, fifo_empty_c;
    logic [DATA_WIDTH-1:0]   fifo_head_c;
    logic [ADDR_WIDTH:0]     fifo_count;

    // Async assert, synchronous release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) {rst_sync_n, rst_meta_n} <= 2'b00;
        else          {rst_sync_n, rst_meta_n} <= {rst_meta_n, 1'b1};
    end

`ifdef CHIRP_SEQ_CKSUM_EN
    localparam parser_state_e P_AFTER = P_CKSUM;
    logic [DATA_WIDTH-1:0] ck_q;

    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            ck_q <= '0;
        end else if (bus.i_rx_valid) begin
            case (p_state)
                P_OP:          ck_q <= bus.i_rx_data;
                P_LEN, P_DATA: ck_q <= ck_q ^ bus.i_rx_data;
                default:       ck_q <= '0;
            endcase
        end
    end

    assign fifo_commit_c  = (p_state == P_CKSUM) && bus.i_rx_valid && (bus.i_rx_data == ck_q);
    assign fifo_discard_c = (p_state == P_CKSUM) && bus.i_rx_valid && (bus.i_rx_data != ck_q);
    assign bad_cksum_c    = fifo_discard_c;
`else
    localparam parser_state_e P_AFTER = P_EXEC;
    assign fifo_commit_c  = 1'b1;
    assign fifo_discard_c = 1'b0;
    assign bad_cksum_c    = 1'b0;
`endif

    // Frame parser; P_EXEC also accepts a header so back-to-back frames lose nothing.
    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            p_state <= P_HDR;
            op      <= '0;
            len     <= '0;
            cnt     <= '0;
            data0   <= '0;
        end else begin
            case (p_state)
                P_HDR, P_EXEC: begin
                    if (bus.i_rx_valid && bus.i_rx_data == DATA_WIDTH'(CMD_HDR)) p_state <= P_OP;
                    else p_state <= P_HDR;
                end
                P_OP: if (bus.i_rx_valid) begin
                    op      <= bus.i_rx_data;
                    p_state <= P_LEN;
                end
                P_LEN: if (bus.i_rx_valid) begin
                    len     <= bus.i_rx_data;
                    cnt     <= '0;
                    p_state <= (bus.i_rx_data == '0) ? P_AFTER : P_DATA;
                end
                P_DATA: if (bus.i_rx_valid) begin
                    if (cnt == '0) data0 <= bus.i_rx_data;
                    cnt <= cnt + DATA_WIDTH'(1);
                    if (cnt == len - DATA_WIDTH'(1)) p_state <= P_AFTER;
                end
`ifdef CHIRP_SEQ_CKSUM_EN
                P_CKSUM: if (bus.i_rx_valid) p_state <= fifo_commit_c ? P_EXEC : P_HDR;
`endif
                default: p_state <= P_HDR;
            endcase
        end
    end

    // Command decode, active only in the single execute cycle.
    always_comb begin
        set_sf_c   = 1'b0;
        set_bw_c   = 1'b0;
        start_c    = 1'b0;
        abort_c    = 1'b0;
        clr_c      = 1'b0;
        bad_cmd_c  = 1'b0;
        busy_cfg_c = 1'b0;
        if (p_state == P_EXEC) begin
            case (op)
                DATA_WIDTH'(OP_SET_SF): begin
                    if (len != DATA_WIDTH'(1)) bad_cmd_c = 1'b1;
                    else if (busy_q) busy_cfg_c = 1'b1;
                    else if (data0 >= DATA_WIDTH'(SF_MIN) && data0 <= DATA_WIDTH'(SF_MAX)) set_sf_c = 1'b1;
                    else bad_cmd_c = 1'b1;
                end
                DATA_WIDTH'(OP_SET_BW): begin
                    if (len != DATA_WIDTH'(1)) bad_cmd_c = 1'b1;
                    else if (busy_q) busy_cfg_c = 1'b1;
                    else set_bw_c = 1'b1;
                end
                DATA_WIDTH'(OP_LOAD): ;
                DATA_WIDTH'(OP_START): begin
                    if (len != '0 || fifo_empty_c) bad_cmd_c = 1'b1;
                    else start_c = (seq_state == S_IDLE);
                end
                DATA_WIDTH'(OP_ABORT): begin
                    if (len != '0) bad_cmd_c = 1'b1;
                    else abort_c = 1'b1;
                end
                DATA_WIDTH'(OP_CLR_ERR): begin
                    if (len != '0) bad_cmd_c = 1'b1;
                    else clr_c = 1'b1;
                end
                default: bad_cmd_c = 1'b1;
            endcase
        end
    end

    assign fifo_push_c  = (p_state == P_DATA) && bus.i_rx_valid && (op == DATA_WIDTH'(OP_LOAD));
    assign fifo_pop_c   = (seq_state == S_START);
    assign fifo_empty_c = (fifo_count == '0);
    assign ovf_c        = fifo_push_c && fifo_full_c && !fifo_pop_c;

    chirp_sym_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (rst_sync_n),
        .push      (fifo_push_c),
        .push_data (bus.i_rx_data),
        .commit    (fifo_commit_c),
        .discard   (fifo_discard_c),
        .pop       (fifo_pop_c),
        .flush     (abort_c),
        .head_c    (fifo_head_c),
        .full_c    (fifo_full_c),
        .count     (fifo_count)
    );

    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            sf_q  <= MAX_SF_WIDTH'(SF_MIN);
            bw_q  <= '0;
            err_q <= '0;
        end else begin
            if (set_sf_c) sf_q <= MAX_SF_WIDTH'(data0);
            if (set_bw_c) bw_q <= data0[BW_BITWIDTH-1:0];
            err_q <= (clr_c ? '0 : err_q) | {bad_cksum_c, ovf_c, busy_cfg_c, bad_cmd_c};
        end
    end

    // Sequencer; done_n is ignored while o_start is high, giving 3-cycle minimum spacing.
    always_comb begin
        seq_next = seq_state;
        case (seq_state)
            S_IDLE:  if (start_c) seq_next = S_START;
            S_START: seq_next = S_WAIT;
            S_WAIT:  if (!start_q && !bus.i_done_n) seq_next = fifo_empty_c ? S_IDLE : S_START;
            default: seq_next = S_IDLE;
        endcase
        if (abort_c) seq_next = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            seq_state <= S_IDLE;
            start_q   <= 1'b0;
            symbol_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            seq_state <= seq_next;
            busy_q    <= (seq_next != S_IDLE);
            start_q   <= (seq_state == S_START) && (seq_next == S_WAIT);
            if ((seq_state == S_START) && (seq_next == S_WAIT)) symbol_q <= fifo_head_c;
        end
    end

    assign bus.o_start  = start_q;
    assign bus.o_symbol = symbol_q;
    assign bus.o_sf     = sf_q;
    assign bus.o_bw     = bw_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_err    = err_q;
endmodule

// File: tb/tb_chirp_seq_ctrl.sv
// Scoreboard bench for chirp_seq_ctrl: expected chirps are queued at stimulus time
// and checked by an independent monitor on every o_start pulse.
`timescale 1ns/1ps
module tb_chirp_seq_ctrl;
    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [7:0] sym;
        logic [7:0] sf;
        logic [1:0] bw;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    int     n_vec = 0;
    int     n_err = 0;
    int     n_starts = 0;
    longint cyc = 0;
    longint last_start = -1;
    bit     gen_en = 1'b0;
    exp_t   exp_q[$];

    chirp_seq_ctrl_if bus ();

    chirp_seq_ctrl dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [7:0] sym, input logic [7:0] sf, input logic [1:0] bw);
        exp_t e;
        e.sym = sym;
        e.sf  = sf;
        e.bw  = bw;
        return e;
    endfunction

    function automatic byte_q_t mk_frame(input logic [7:0] op, input byte_q_t pl);
        byte_q_t q;
        q.push_back(8'hA5);
        q.push_back(op);
        q.push_back(8'(pl.size()));
        foreach (pl[i]) q.push_back(pl[i]);
`ifdef CHIRP_SEQ_CKSUM_EN
        begin
            logic [7:0] ck;
            ck = op ^ 8'(pl.size());
            foreach (pl[i]) ck = ck ^ pl[i];
            q.push_back(ck);
        end
`endif
        return q;
    endfunction

    task automatic send_bytes(input byte_q_t q, input bit b2b);
        foreach (q[i]) begin
            @(negedge clk);
            bus.i_rx_data  = q[i];
            bus.i_rx_valid = 1'b1;
            if (!b2b) begin
                @(negedge clk);
                bus.i_rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] op, input byte_q_t pl, input bit b2b);
        send_bytes(mk_frame(op, pl), b2b);
    endtask

    task automatic cmd0(input logic [7:0] op);
        byte_q_t pl;
        send_frame(op, pl, 1'b0);
    endtask

    task automatic cmd1(input logic [7:0] op, input logic [7:0] b);
        byte_q_t pl;
        pl.push_back(b);
        send_frame(op, pl, 1'b0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i = 0;
        while ((bus.o_busy || exp_q.size() != 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_in_time"}, 32'(i < budget), 32'd1);
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_busy(input string name, input int budget);
        int i = 0;
        while (!bus.o_busy && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_busy"}, 32'(bus.o_busy), 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_start"},  32'(bus.o_start),  32'd0);
        chk({tag, "_symbol"}, 32'(bus.o_symbol), 32'd0);
        chk({tag, "_sf"},     32'(bus.o_sf),     32'd7);
        chk({tag, "_bw"},     32'(bus.o_bw),     32'd0);
        chk({tag, "_busy"},   32'(bus.o_busy),   32'd0);
        chk({tag, "_err"},    32'(bus.o_err),    32'd0);
    endtask

    // Chirp generator model: done_n low for one cycle, 5 cycles after each start.
    initial begin : generator
        bus.i_done_n = 1'b1;
        forever begin
            @(negedge clk);
            if (gen_en && rst_n && bus.o_start) begin
                repeat (5) @(negedge clk);
                bus.i_done_n = 1'b0;
                @(negedge clk);
                bus.i_done_n = 1'b1;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_start) begin
                if (last_start >= 0) chk("start_spacing_ge3", 32'((cyc - last_start) >= 3), 32'd1);
                last_start = cyc;
                n_starts++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_start: symbol 0x%0h with nothing queued", bus.o_symbol);
                end else begin
                    e = exp_q.pop_front();
                    chk("start_symbol", 32'(bus.o_symbol), 32'(e.sym));
                    chk("start_sf",     32'(bus.o_sf),     32'(e.sf));
                    chk("start_bw",     32'(bus.o_bw),     32'(e.bw));
                end
            end
        end
    end

    initial begin : watchdog
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin : stim
        byte_q_t pl, q, f;
        bus.i_rx_data  = '0;
        bus.i_rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Config writes, then an out-of-range SF
        cmd1(8'h01, 8'h09);
        cmd1(8'h02, 8'h02);
        chk("sf_set9", 32'(bus.o_sf), 32'd9);
        chk("bw_set2", 32'(bus.o_bw), 32'd2);
        chk("cfg_err_clean", 32'(bus.o_err), 32'h0);
        cmd1(8'h01, 8'h0D);
        chk("sf_range_keep", 32'(bus.o_sf), 32'd9);
        chk("sf_range_err", 32'(bus.o_err), 32'h1);
        cmd0(8'h06);
        chk("clr_err", 32'(bus.o_err), 32'h0);

        // Three-symbol burst, LOAD and START sent back to back
        gen_en = 1'b1;
        pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
        q = mk_frame(8'h03, pl);
        pl.delete();
        f = mk_frame(8'h04, pl);
        foreach (f[i]) q.push_back(f[i]);
        exp_q.push_back(mk_exp(8'h11, 8'd9, 2'd2));
        exp_q.push_back(mk_exp(8'h22, 8'd9, 2'd2));
        exp_q.push_back(mk_exp(8'h33, 8'd9, 2'd2));
        send_bytes(q, 1'b1);
        wait_idle("burst3", 300);
        chk("burst3_starts", 32'(n_starts), 32'd3);
        chk("burst3_err", 32'(bus.o_err), 32'h0);

        // 17 bytes into an empty 16-deep FIFO
        pl.delete();
        for (int i = 0; i < 17; i++) pl.push_back(8'(8'h40 + i));
        send_frame(8'h03, pl, 1'b1);
        chk("ovf_err", 32'(bus.o_err), 32'h4);
        for (int i = 0; i < 16; i++) exp_q.push_back(mk_exp(8'(8'h40 + i), 8'd9, 2'd2));
        cmd0(8'h04);
        wait_idle("ovf16", 800);
        chk("ovf16_starts", 32'(n_starts), 32'd19);
        cmd0(8'h06);

        // START with empty FIFO
        cmd0(8'h04);
        repeat (10) @(negedge clk);
        chk("start_empty_err", 32'(bus.o_err), 32'h1);
        chk("start_empty_busy", 32'(bus.o_busy), 32'd0);
        chk("start_empty_nostart", 32'(n_starts), 32'd19);
        cmd0(8'h06);

        // Config write during a burst, then ABORT with the chirp still in flight
        gen_en = 1'b0;
        pl.delete();
        pl.push_back(8'h61); pl.push_back(8'h62); pl.push_back(8'h63);
        send_frame(8'h03, pl, 1'b0);
        exp_q.push_back(mk_exp(8'h61, 8'd9, 2'd2));
        cmd0(8'h04);
        wait_busy("abort_burst", 50);
        repeat (3) @(negedge clk);
        cmd1(8'h01, 8'h0A);
        chk("busy_cfg_sf_keep", 32'(bus.o_sf), 32'd9);
        chk("busy_cfg_err", 32'(bus.o_err), 32'h2);
        chk("busy_cfg_still_busy", 32'(bus.o_busy), 32'd1);
        cmd0(8'h05);
        chk("abort_busy", 32'(bus.o_busy), 32'd0);
        repeat (20) @(negedge clk);
        chk("abort_starts", 32'(n_starts), 32'd20);
        chk("abort_queue", 32'(exp_q.size()), 32'd0);
        cmd0(8'h04);
        chk("abort_flushed", 32'(bus.o_err), 32'h3);
        cmd0(8'h06);

        // Unknown opcode and LEN mismatch consume payload without effect
        pl.delete();
        pl.push_back(8'h01); pl.push_back(8'h02);
        send_frame(8'h07, pl, 1'b0);
        chk("bad_op_err", 32'(bus.o_err), 32'h1);
        pl.delete();
        pl.push_back(8'h03); pl.push_back(8'h01);
        send_frame(8'h02, pl, 1'b0);
        chk("bw_len_keep", 32'(bus.o_bw), 32'd2);
        chk("bw_len_err", 32'(bus.o_err), 32'h1);
        cmd0(8'h06);
        chk("clr_err2", 32'(bus.o_err), 32'h0);

`ifdef CHIRP_SEQ_CKSUM_EN
        // Raw frames: one good checksum, one bad
        gen_en = 1'b1;
        q.delete();
        q.push_back(8'hA5); q.push_back(8'h03); q.push_back(8'h01); q.push_back(8'h44); q.push_back(8'h46);
        send_bytes(q, 1'b0);
        q.delete();
        q.push_back(8'hA5); q.push_back(8'h03); q.push_back(8'h01); q.push_back(8'h44); q.push_back(8'h00);
        send_bytes(q, 1'b0);
        chk("cksum_bad_err", 32'(bus.o_err), 32'h8);
        exp_q.push_back(mk_exp(8'h44, 8'd9, 2'd2));
        cmd0(8'h04);
        wait_idle("cksum", 100);
        chk("cksum_starts", 32'(n_starts), 32'd21);
        cmd0(8'h06);
        gen_en = 1'b0;
`endif

        // Reset asserted while the sequencer waits for done
        pl.delete();
        pl.push_back(8'h71); pl.push_back(8'h72);
        send_frame(8'h03, pl, 1'b0);
        exp_q.push_back(mk_exp(8'h71, 8'd9, 2'd2));
        cmd0(8'h04);
        wait_busy("midrst", 50);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        cmd0(8'h04);
        chk("midrst_fifo_empty", 32'(bus.o_err), 32'h1);
        chk("midrst_idle", 32'(bus.o_busy), 32'd0);
        repeat (10) @(negedge clk);
        chk("midrst_queue", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
